enqueue_agent: RTL and testbench

Per-packet admission controller between the packet pipeline and five output queues: physical ports 0-3 plus a CPU/DMA queue (index 4). It decodes the destination bitmap in SUME metadata and masks out queues whose buffer or PIFO is almost full. It then drives per-queue buffer write enables and PIFO insert enables. It keeps per-(source, destination) congestion drop counters that the CPU reads through a simple request/response channel.

---
 rtl/enqueue_agent.sv | 136 +++++++++++++
 tb/tb_enqueue_agent.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/enqueue_agent.sv
// Per-packet admission control into five output queues: masks congested queues,
// drives buffer write / PIFO insert enables and keeps per-(src,dst) drop counters.
module enqueue_agent #(
  parameter int unsigned NUM_Q   = 5,
  parameter int unsigned TUSER_W = 128,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               axis_aclk,
  input  logic               axis_resetn,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [TUSER_W-1:0] s_axis_tuser,
  input  logic               s_axis_tlast,
  input  logic [NUM_Q-1:0]   s_axis_buffer_almost_full,
  input  logic [NUM_Q-1:0]   s_axis_pifo_full,
  output logic [NUM_Q-1:0]   m_axis_ctl_pifo_in_en,
  output logic [NUM_Q-1:0]   m_axis_ctl_buffer_wr_en,
  input  logic [7:0]         s_axi_addr,
  input  logic               s_axi_req_valid,
  output logic [CNT_W-1:0]   m_axi_data,
  output logic               m_axi_resp_valid
);

  localparam int unsigned SRC_W  = 3;
  localparam int unsigned PHYS_Q = 4;

  logic               beat;
  logic               first;
  logic               drop_bit;
  logic               in_pkt;
  logic [NUM_Q-1:0]   req;
  logic [NUM_Q-1:0]   congested;
  logic [NUM_Q-1:0]   admit;
  logic [NUM_Q-1:0]   cong_drop;
  logic [NUM_Q-1:0]   mask_r;
  logic [NUM_Q-1:0]   beat_mask;
  logic               src_valid;
  logic [SRC_W-1:0]   src_idx;
  logic [CNT_W-1:0]   cnt [NUM_Q][NUM_Q];
  logic [CNT_W-1:0]   rd_val;
  logic               unused_tuser;

  assign unused_tuser = ^{s_axis_tuser[TUSER_W-1:33], s_axis_tuser[15:0]};

  // The block never back-pressures; ready only drops while reset is held.
  assign s_axis_tready = ~axis_resetn;
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign first         = beat & ~in_pkt;
  assign drop_bit      = s_axis_tuser[32];

  // Even dst bits select physical queues; any odd dst bit selects the CPU queue.
  always_comb begin
    req = '0;
    for (int i = 0; i < PHYS_Q; i++) begin
      req[i] = s_axis_tuser[24 + 2*i];
    end
    req[PHYS_Q] = s_axis_tuser[25] | s_axis_tuser[27] | s_axis_tuser[29] | s_axis_tuser[31];
  end

  assign congested = s_axis_buffer_almost_full | s_axis_pifo_full;
  assign admit     = req & ~congested & {NUM_Q{~drop_bit}};
  assign cong_drop = req &  congested & {NUM_Q{~drop_bit}};

  // Lowest set src bit wins: descending scan so the last hit is the lowest.
  always_comb begin
    src_valid = 1'b0;
    src_idx   = '0;
    for (int k = 7; k >= 0; k--) begin
      if (s_axis_tuser[16 + k]) begin
        src_valid = 1'b1;
        src_idx   = (k % 2 == 1) ? SRC_W'(PHYS_Q) : SRC_W'(k / 2);
      end
    end
  end

  assign beat_mask               = beat ? (first ? admit : mask_r) : '0;
  assign m_axis_ctl_buffer_wr_en = beat_mask;
  assign m_axis_ctl_pifo_in_en   = s_axis_tlast ? beat_mask : '0;

  // Packet tracking: mask is frozen on the first beat for the rest of the packet.
  always_ff @(posedge axis_aclk or posedge axis_resetn) begin
    if (axis_resetn) begin
      in_pkt <= 1'b0;
      mask_r <= '0;
    end else begin
      if (first) begin
        mask_r <= admit;
      end
      if (beat) begin
        in_pkt <= first ? ~s_axis_tlast : (in_pkt & ~s_axis_tlast);
      end
    end
  end

  // Saturating congestion-drop counters, updated once per packet.
  always_ff @(posedge axis_aclk or posedge axis_resetn) begin
    if (axis_resetn) begin
      for (int s = 0; s < NUM_Q; s++) begin
        for (int q = 0; q < NUM_Q; q++) begin
          cnt[s][q] <= '0;
        end
      end
    end else if (first && src_valid) begin
      for (int s = 0; s < NUM_Q; s++) begin
        for (int q = 0; q < NUM_Q; q++) begin
          if (src_idx == SRC_W'(s) && cong_drop[q] && cnt[s][q] != '1) begin
            cnt[s][q] <= cnt[s][q] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int s = 0; s < NUM_Q; s++) begin
      for (int q = 0; q < NUM_Q; q++) begin
        if (s_axi_addr[7:4] == 4'(s) && s_axi_addr[3:0] == 4'(q)) begin
          rd_val = cnt[s][q];
        end
      end
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_resetn) begin
    if (axis_resetn) begin
      m_axi_resp_valid <= 1'b0;
      m_axi_data       <= '0;
    end else begin
      m_axi_resp_valid <= s_axi_req_valid;
      m_axi_data       <= s_axi_req_valid ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_enqueue_agent.sv
// Directed bench for enqueue_agent: admission masks, enable timing, drop counters,
// CPU reads and mid-packet reset.
module tb_enqueue_agent;

  logic         clk = 1'b0;
  logic         rst;
  logic         tvalid;
  logic         tready;
  logic [127:0] tuser;
  logic         tlast;
  logic [4:0]   baf;
  logic [4:0]   pf;
  logic [4:0]   pifo_en;
  logic [4:0]   wr_en;
  logic [7:0]   addr;
  logic         req_valid;
  logic [31:0]  rdata;
  logic         resp_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enqueue_agent dut (
    .axis_aclk                 (clk),
    .axis_resetn               (rst),
    .s_axis_tvalid             (tvalid),
    .s_axis_tready             (tready),
    .s_axis_tuser              (tuser),
    .s_axis_tlast              (tlast),
    .s_axis_buffer_almost_full (baf),
    .s_axis_pifo_full          (pf),
    .m_axis_ctl_pifo_in_en     (pifo_en),
    .m_axis_ctl_buffer_wr_en   (wr_en),
    .s_axi_addr                (addr),
    .s_axi_req_valid           (req_valid),
    .m_axi_data                (rdata),
    .m_axi_resp_valid          (resp_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_tuser(input logic [7:0] dst, input logic [7:0] src,
                                            input logic drop);
    logic [127:0] t;
    t = '0;
    t[31:24] = dst;
    t[23:16] = src;
    t[32]    = drop;
    return t;
  endfunction

  // Called at posedge+1; flags are flipped after the first beat to prove they are ignored.
  task automatic send_pkt(input string tag, input logic [7:0] dst, input logic [7:0] src,
                          input logic drop, input int n, input logic [4:0] b,
                          input logic [4:0] p, input logic [4:0] exp);
    for (int i = 0; i < n; i++) begin
      tvalid = 1'b1;
      tuser  = mk_tuser(dst, src, drop);
      tlast  = (i == n - 1);
      baf    = (i == 0) ? b : ~b;
      pf     = (i == 0) ? p : ~p;
      #2;
      check({tag, "_wr"}, 32'(wr_en), 32'(exp));
      check({tag, "_pifo"}, 32'(pifo_en), (i == n - 1) ? 32'(exp) : 32'd0);
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    baf    = '0;
    pf     = '0;
  endtask

  // Back-to-back reads; each response checked one cycle after its request.
  task automatic read_seq(input string tag, input logic [7:0] a [], input logic [31:0] e []);
    for (int i = 0; i < a.size(); i++) begin
      addr      = a[i];
      req_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, "_rv"}, 32'(resp_valid), 32'd1);
      check({tag, "_data"}, rdata, e[i]);
    end
    req_valid = 1'b0;
    addr      = '0;
    @(posedge clk); #1;
    check({tag, "_idle"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    tvalid    = 1'b0;
    tuser     = '0;
    tlast     = 1'b0;
    baf       = '0;
    pf        = '0;
    addr      = '0;
    req_valid = 1'b0;
    #2;
    check("rst_tready", 32'(tready), 32'd0);
    check("rst_wr", 32'(wr_en), 32'd0);
    check("rst_rv", 32'(resp_valid), 32'd0);
    check("rst_data", rdata, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("tready", 32'(tready), 32'd1);
    @(posedge clk); #1;

    send_pkt("t1", 8'h41, 8'h00, 1'b0, 2, 5'b01110, 5'b00000, 5'b00001);
    check("idle_wr", 32'(wr_en), 32'd0);
    send_pkt("t2", 8'h54, 8'h00, 1'b0, 3, 5'b00000, 5'b00000, 5'b01110);
    send_pkt("t3", 8'h54, 8'h04, 1'b0, 3, 5'b00000, 5'b01110, 5'b00000);
    read_seq("rd_t3", '{8'h10, 8'h11, 8'h12, 8'h13}, '{32'd0, 32'd1, 32'd1, 32'd1});

    // src via odd bit 17 maps to CPU source 4
    send_pkt("t4", 8'h54, 8'h02, 1'b0, 1, 5'b00100, 5'b00010, 5'b01000);
    read_seq("rd_t4", '{8'h41, 8'h42, 8'h43, 8'h51}, '{32'd1, 32'd1, 32'd0, 32'd0});

    send_pkt("t5", 8'h03, 8'h00, 1'b0, 1, 5'b00000, 5'b00000, 5'b10001);
    send_pkt("t6", 8'h08, 8'h00, 1'b0, 2, 5'b00000, 5'b00000, 5'b10000);
    send_pkt("t7", 8'h15, 8'h01, 1'b1, 2, 5'b11111, 5'b00000, 5'b00000);
    // lowest src bit wins: bits 18 and 22 -> src 1
    send_pkt("t8", 8'h40, 8'h44, 1'b0, 1, 5'b01000, 5'b00000, 5'b00000);
    read_seq("rd_t78", '{8'h00, 8'h01, 8'h02, 8'h13, 8'h33}, '{32'd0, 32'd0, 32'd0, 32'd2, 32'd0});

    // Read coinciding with an increment returns the old value.
    tvalid    = 1'b1;
    tuser     = mk_tuser(8'h04, 8'h04, 1'b0);
    tlast     = 1'b1;
    pf        = 5'b00010;
    addr      = 8'h11;
    req_valid = 1'b1;
    @(posedge clk); #1;
    tvalid    = 1'b0;
    tlast     = 1'b0;
    pf        = '0;
    req_valid = 1'b0;
    check("coin_data", rdata, 32'd1);
    read_seq("rd_coin", '{8'h11}, '{32'd2});

    // Mid-packet reset
    tvalid = 1'b1;
    tuser  = mk_tuser(8'h01, 8'h00, 1'b0);
    tlast  = 1'b0;
    #2;
    check("mid_wr", 32'(wr_en), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_wr", 32'(wr_en), 32'd0);
    check("mid_rst_pifo", 32'(pifo_en), 32'd0);
    check("mid_rst_tready", 32'(tready), 32'd0);
    tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_pkt("post", 8'h10, 8'h00, 1'b0, 2, 5'b00000, 5'b00000, 5'b00100);
    read_seq("rd_post", '{8'h11, 8'h12, 8'h13, 8'h41}, '{32'd0, 32'd0, 32'd0, 32'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
